// File: rtl/enc_test_pkg.sv
// Shared definitions for the encoder emulator/tester family.
// State encoding, quadrature phase table and default widths.
package enc_test_pkg;

  localparam int PPR_W_DEF = 16;
  localparam int DIV_W_DEF = 32;
  localparam int REV_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  // {A,B} per phase when A leads B
  localparam logic [1:0] PH_AB [4] = '{
    2'b00, 2'b10, 2'b11, 2'b01
  };

  function automatic logic [1:0] phase_ab(
    input logic [1:0] ph,
    input logic       dir
  );
    logic [1:0] ab;
    ab = PH_AB[ph];
    return dir ? ab : {ab[0], ab[1]};
  endfunction

endpackage

// File: rtl/rise_pulse.sv
// Rising-edge detector with registered history.
// Pulse is high for the cycle in which In rises.
module rise_pulse (
  input  logic Clk,
  input  logic RstN,
  input  logic In,
  output logic Pulse
);

  logic hist_q;

  // History parks high in reset so a level held
  // through reset never reads as a fresh edge.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= In;
    end
  end

  assign Pulse = In & ~hist_q;

endmodule

// File: rtl/quad_enc_emulator.sv
// Synthetic quadrature encoder source (A/B/Z) with
// programmable PPR, quarter-step period and rev count.
module quad_enc_emulator
  import enc_test_pkg::*;
#(
  parameter int PPR_W = PPR_W_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int REV_W = REV_W_DEF
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Start,
  input  logic             Stop,
  input  logic [PPR_W-1:0] PPRSet,
  input  logic [DIV_W-1:0] QtrPeriod,
  input  logic [REV_W-1:0] Revs,
  input  logic             Dir,
  output logic             AOut,
  output logic             BOut,
  output logic             ZOut,
  output logic             Busy,
  output logic             Done,
  output logic [PPR_W-1:0] PulseCnt,
  output logic [REV_W-1:0] RevCnt
);

  state_t state_q, state_d;

  logic start_p;

  logic [PPR_W-1:0] ppr_q, ppr_d;
  logic [DIV_W-1:0] qset_q, qset_d;
  logic [REV_W-1:0] revs_q, revs_d;
  logic             dir_q, dir_d;

  logic [DIV_W-1:0] tmr_q, tmr_d;
  logic [1:0]       ph_q, ph_d;
  logic [PPR_W-1:0] pc_q, pc_d;
  logic [REV_W-1:0] rc_q, rc_d;

  logic a_q, a_d;
  logic b_q, b_d;
  logic z_q, z_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [DIV_W-1:0] tmr_last;
  logic [PPR_W-1:0] pc_last;
  logic [REV_W-1:0] rc_inc;
  logic             tick;
  logic             pc_wrap;
  logic             rev_done;
  logic             launch;

  rise_pulse u_start (
    .Clk   (Clk),
    .RstN  (RstN),
    .In    (Start),
    .Pulse (start_p)
  );

  // Zero settings behave as one
  assign tmr_last = (qset_q == '0) ? '0
                  : qset_q - 1'b1;
  assign pc_last  = (ppr_q == '0) ? '0
                  : ppr_q - 1'b1;

  assign tick    = (tmr_q == tmr_last);
  assign pc_wrap = tick && (ph_q == 2'd3)
                && (pc_q == pc_last);
  assign rc_inc  = (&rc_q) ? rc_q : rc_q + 1'b1;

  assign rev_done = pc_wrap && (revs_q != '0)
                 && (rc_inc == revs_q);

  assign launch = (state_q == ST_IDLE)
               && (state_d == ST_RUN);

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!Stop && start_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (Stop)          state_d = ST_IDLE;
        else if (rev_done) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (Stop || tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ppr_d  = ppr_q;
    qset_d = qset_q;
    revs_d = revs_q;
    dir_d  = dir_q;
    tmr_d  = tmr_q;
    ph_d   = ph_q;
    pc_d   = pc_q;
    rc_d   = rc_q;
    unique case (1'b1)
      launch: begin
        ppr_d  = PPRSet;
        qset_d = QtrPeriod;
        revs_d = Revs;
        dir_d  = Dir;
        tmr_d  = '0;
        ph_d   = 2'd0;
        pc_d   = '0;
        rc_d   = '0;
      end
      (state_q == ST_RUN) && !Stop: begin
        tmr_d = tick ? '0 : tmr_q + 1'b1;
        if (tick) begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd3) begin
            pc_d = pc_wrap ? '0 : pc_q + 1'b1;
            if (pc_wrap) rc_d = rc_inc;
          end
        end
      end
      (state_q == ST_FINISH): begin
        tmr_d = tick ? '0 : tmr_q + 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Next output values, registered below
  always_comb begin
    a_d    = 1'b0;
    b_d    = 1'b0;
    z_d    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      ST_RUN: begin
        {a_d, b_d} = phase_ab(ph_d, dir_d);
        z_d    = (ph_d == 2'd0) && (pc_d == '0);
        busy_d = 1'b1;
      end
      ST_FINISH: begin
        z_d    = 1'b1;
        busy_d = 1'b1;
      end
      ST_IDLE: begin
        done_d = (state_q == ST_FINISH)
              && tick && !Stop;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      ppr_q  <= '0;
      qset_q <= '0;
      revs_q <= '0;
      dir_q  <= 1'b0;
      tmr_q  <= '0;
      ph_q   <= 2'd0;
      pc_q   <= '0;
      rc_q   <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      z_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ppr_q  <= ppr_d;
      qset_q <= qset_d;
      revs_q <= revs_d;
      dir_q  <= dir_d;
      tmr_q  <= tmr_d;
      ph_q   <= ph_d;
      pc_q   <= pc_d;
      rc_q   <= rc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      z_q    <= z_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign AOut     = a_q;
  assign BOut     = b_q;
  assign ZOut     = z_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign PulseCnt = pc_q;
  assign RevCnt   = rc_q;

endmodule
